// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and constants for the PLL reset sequencer
//
// Purpose: sequencer state encoding, which is also the seq_state debug
//          encoding read by status logic, plus the fault counter width
//          and small helper functions.
// Ports:   none (package)

package pll_seq_pkg;

  localparam int FAULT_W     = 8;
  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seq_state_e;

  // One shared down-counter serves every timed state, so it is sized for the
  // longest interval. Never narrower than one bit, even when all intervals
  // are a single cycle.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int w;
    w = 1;
    if ($clog2(a) > w) w = $clog2(a);
    if ($clog2(b) > w) w = $clog2(b);
    if ($clog2(c) > w) w = $clog2(c);
    if ($clog2(d) > w) w = $clog2(d);
    return w;
  endfunction

  function automatic logic [FAULT_W-1:0] fault_sat_inc(input logic [FAULT_W-1:0] v);
    return (&v) ? v : v + FAULT_W'(1);
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - sequencer-to-PLL/domain signal bundle
//
// Purpose: groups the PLL handshake, domain resets and status outputs.
// Ports (master = sequencer side):
//   pll_locked   in   raw PLL lock, asynchronous
//   relock_req   in   one-cycle re-lock request
//   pll_rst      out  active-high PLL reset
//   domain_rst_n out  active-low per-domain resets, bit 0 released first
//   ready        out  high only in RUN
//   fault_count  out  saturating timeout + lock-loss count
//   seq_state    out  debug state encoding

interface pll_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 5
);
  import pll_seq_pkg::*;

  logic                   pll_locked;
  logic                   relock_req;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic                   ready;
  logic [FAULT_W-1:0]     fault_count;
  logic [SEQ_STATE_W-1:0] seq_state;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, domain_rst_n, ready, fault_count, seq_state
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, domain_rst_n, ready, fault_count, seq_state
  );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchroniser
//
// Purpose: brings an asynchronous level into the clk domain; output is 0
//          while reset is held.
// Ports:
//   clk    in  destination clock
//   rst_n  in  synchronous active-low reset
//   d      in  asynchronous input
//   q      out synchronised output, two cycles of latency

module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset, lock qualification and staggered domain release
//
// Purpose: pulses the PLL reset, waits for a synchronised lock, qualifies it
//          as stable, then releases domain resets one at a time. Lock loss or
//          relock_req in RUN restarts the sequence.
// Ports:
//   refclk  in  free-running board reference clock
//   rst_n   in  synchronous active-low reset
//   bus     master modport of pll_reset_sequencer_if
// Build option: PLLSEQ_RETRY_LIMIT_EN adds a retry limit and the FAIL state.

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int NUM_DOMAINS    = 5,
`ifdef PLLSEQ_RETRY_LIMIT_EN
  parameter int STAGGER_CYCLES = 64,
  parameter int MAX_RETRIES    = 7
`else
  parameter int STAGGER_CYCLES = 64
`endif
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_reset_sequencer_if.master bus
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  // Each timed state spends (load + 1) cycles before its counter reaches 0.
  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FAULT_W-1:0]     fault_q, fault_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   lk;

`ifdef PLLSEQ_RETRY_LIMIT_EN
  logic [3:0] retry_q, retry_d;
`endif

  sync2 #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lk)
  );

  // Reset is treated as an entry into PLL_RST, so the counter takes the
  // PLL_RST load and the first post-reset pulse is full length.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= RST_LOAD;
      fault_q <= '0;
      dom_q   <= '0;
      idx_q   <= '0;
`ifdef PLLSEQ_RETRY_LIMIT_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      dom_q   <= dom_d;
      idx_q   <= idx_d;
`ifdef PLLSEQ_RETRY_LIMIT_EN
      retry_q <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    fault_d = fault_q;
    dom_d   = dom_q;
    idx_d   = idx_q;
`ifdef PLLSEQ_RETRY_LIMIT_EN
    retry_d = retry_q;
`endif

    case (state_q)
      PLL_RST: begin
        dom_d = '0;
        if (cnt_q == '0) begin
          state_d = WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end
      end

      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_q == '0) begin
          fault_d = fault_sat_inc(fault_q);
          cnt_d   = RST_LOAD;
`ifdef PLLSEQ_RETRY_LIMIT_EN
          retry_d = (&retry_q) ? retry_q : retry_q + 4'd1;
          // This timeout pushes the count past the limit.
          state_d = (retry_q >= 4'(MAX_RETRIES)) ? FAIL : PLL_RST;
`else
          state_d = PLL_RST;
`endif
        end
      end

      STABLE: begin
        // A drop here is a lock that never settled, not a fault.
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = RELEASE;
          cnt_d   = STAGGER_LOAD;
          dom_d   = NUM_DOMAINS'(1);
          idx_d   = IDX_W'(1);
        end
      end

      RELEASE: begin
        if (!lk) begin
          state_d = PLL_RST;
          cnt_d   = RST_LOAD;
          fault_d = fault_sat_inc(fault_q);
          dom_d   = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = RUN;
        end else if (cnt_q == '0) begin
          dom_d = dom_q | (NUM_DOMAINS'(1) << idx_q);
          idx_d = idx_q + IDX_W'(1);
          cnt_d = STAGGER_LOAD;
        end
      end

      RUN: begin
`ifdef PLLSEQ_RETRY_LIMIT_EN
        retry_d = '0;
`endif
        // Lock loss wins over a simultaneous relock_req: one fault.
        if (!lk) begin
          state_d = PLL_RST;
          cnt_d   = RST_LOAD;
          fault_d = fault_sat_inc(fault_q);
          dom_d   = '0;
        end else if (bus.relock_req) begin
          state_d = PLL_RST;
          cnt_d   = RST_LOAD;
          dom_d   = '0;
        end
      end

`ifdef PLLSEQ_RETRY_LIMIT_EN
      FAIL: begin
        dom_d = '0;
        if (bus.relock_req) begin
          state_d = PLL_RST;
          cnt_d   = RST_LOAD;
          retry_d = '0;
        end
      end
`endif

      default: begin
        state_d = PLL_RST;
        cnt_d   = RST_LOAD;
        dom_d   = '0;
      end
    endcase
  end

`ifdef PLLSEQ_RETRY_LIMIT_EN
  assign bus.pll_rst = (state_q == PLL_RST) || (state_q == FAIL);
`else
  assign bus.pll_rst = (state_q == PLL_RST);
`endif
  assign bus.domain_rst_n = dom_q;
  assign bus.ready        = (state_q == RUN);
  assign bus.fault_count  = fault_q;
  assign bus.seq_state    = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

  logic clk;
  logic rst_n;

  pll_reset_sequencer_if #(.NUM_DOMAINS(3)) bus ();

  pll_reset_sequencer #(
    .RST_CYCLES     (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .NUM_DOMAINS    (3),
`ifdef PLLSEQ_RETRY_LIMIT_EN
    .STAGGER_CYCLES (4),
    .MAX_RETRIES    (2)
`else
    .STAGGER_CYCLES (4)
`endif
  ) dut (
    .refclk (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rst_n;
    bit          locked;
    bit          relock;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {pll_rst, domain_rst_n, ready, fault_count, seq_state}
  function automatic logic [15:0] pack(input bit prst, input logic [2:0] dom, input bit rdy,
                                       input logic [7:0] f, input logic [2:0] st);
    return {prst, dom, rdy, f, st};
  endfunction

  function automatic logic [15:0] outs();
    return {bus.pll_rst, bus.domain_rst_n, bus.ready, bus.fault_count, bus.seq_state};
  endfunction

  task automatic add(input int n, input bit r, input bit lk, input bit rq, input bit prst,
                     input logic [2:0] dom, input bit rdy, input logic [7:0] f, input logic [2:0] st);
    vec_t v;
    v.rst_n = r; v.locked = lk; v.relock = rq; v.exp = pack(prst, dom, rdy, f, st);
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, input string name);
    int n;
    n = 0;
    while (bus.seq_state !== s && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(bus.seq_state), 32'(s));
  endtask

  // One PLL_RST + WAIT_LOCK attempt with lock held low; called at posedge+1
  // on the first PLL_RST cycle.
  task automatic attempt(input int k);
    int hi, lo;
    hi = 0;
    lo = 0;
    while (bus.pll_rst === 1'b1 && hi < 200) begin @(posedge clk); #1; hi++; end
    while (bus.pll_rst === 1'b0 && lo < 200) begin @(posedge clk); #1; lo++; end
    check($sformatf("attempt%0d_rst_cycles", k), 32'(hi), 32'd4);
    check($sformatf("attempt%0d_wait_cycles", k), 32'(lo), 32'd32);
    check($sformatf("attempt%0d_fault", k), 32'(bus.fault_count), 32'(k));
    check($sformatf("attempt%0d_dom", k), 32'(bus.domain_rst_n), 32'd0);
  endtask

  initial begin
    int cyc, to;
    logic [2:0] prev_st;
    logic [7:0] prev_f;

    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;

    // Reset state, power-up sequence, 1-cycle lock drop in RUN,
    // glitch in STABLE, simultaneous relock + lock loss, relock in WAIT_LOCK.
    add(1, 0,0,0, 1,3'b000,0,0,0);
    add(4, 1,0,0, 1,3'b000,0,0,0);
    add(6, 1,0,0, 0,3'b000,0,0,1);
    add(3, 1,1,0, 0,3'b000,0,0,1);
    add(8, 1,1,0, 0,3'b000,0,0,2);
    add(4, 1,1,0, 0,3'b001,0,0,3);
    add(4, 1,1,0, 0,3'b011,0,0,3);
    add(1, 1,1,0, 0,3'b111,0,0,3);
    add(3, 1,1,0, 0,3'b111,1,0,4);
    add(1, 1,0,0, 0,3'b111,1,0,4);
    add(2, 1,1,0, 0,3'b111,1,0,4);
    add(4, 1,1,0, 1,3'b000,0,1,0);
    add(1, 1,1,0, 0,3'b000,0,1,1);
    add(2, 1,1,0, 0,3'b000,0,1,2);
    add(1, 1,0,0, 0,3'b000,0,1,2);
    add(2, 1,1,0, 0,3'b000,0,1,2);
    add(1, 1,1,0, 0,3'b000,0,1,1);
    add(8, 1,1,0, 0,3'b000,0,1,2);
    add(4, 1,1,0, 0,3'b001,0,1,3);
    add(4, 1,1,0, 0,3'b011,0,1,3);
    add(1, 1,1,0, 0,3'b111,0,1,3);
    add(2, 1,1,0, 0,3'b111,1,1,4);
    add(2, 1,0,0, 0,3'b111,1,1,4);
    add(1, 1,0,1, 0,3'b111,1,1,4);
    add(4, 1,0,0, 1,3'b000,0,2,0);
    add(1, 1,0,1, 0,3'b000,0,2,1);
    add(2, 1,0,0, 0,3'b000,0,2,1);

    repeat (3) @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      rst_n          = vecs[k].rst_n;
      bus.pll_locked = vecs[k].locked;
      bus.relock_req = vecs[k].relock;
      @(negedge clk);
      check($sformatf("vec%0d", k), 32'(outs()), 32'(vecs[k].exp));
      @(posedge clk); #1;
    end

    // relock_req in RUN with lock held: restart without a fault.
    bus.pll_locked = 1'b1;
    wait_state(3'd4, 100, "reach_run_1");
    bus.relock_req = 1'b1;
    @(posedge clk); #1;
    bus.relock_req = 1'b0;
    check("relock_run_state", 32'(bus.seq_state), 32'd0);
    check("relock_run_fault", 32'(bus.fault_count), 32'd2);
    check("relock_run_dom", 32'(bus.domain_rst_n), 32'd0);

    // rst_n from RUN returns everything to reset values on the next edge.
    wait_state(3'd4, 100, "reach_run_2");
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_from_run", 32'(outs()), 32'(pack(1, 3'b000, 0, 8'd0, 3'd0)));
    bus.pll_locked = 1'b0;
    rst_n = 1'b1;

    // No lock: repeated timeouts.
    attempt(1);
    attempt(2);
    attempt(3);
`ifdef PLLSEQ_RETRY_LIMIT_EN
    check("fail_entered", 32'(bus.seq_state), 32'd5);
    repeat (40) @(posedge clk);
    #1;
    check("fail_held", 32'(outs()), 32'(pack(1, 3'b000, 0, 8'd3, 3'd5)));
    bus.relock_req = 1'b1;
    @(posedge clk); #1;
    bus.relock_req = 1'b0;
    check("fail_relock_state", 32'(bus.seq_state), 32'd0);
    attempt(4);
    check("retry_cleared", 32'(bus.seq_state), 32'd0);
`else
    check("retry_forever", 32'(bus.seq_state), 32'd0);
`endif

    // Saturate fault_count, then see two more timeouts leave it at 255.
    cyc = 0;
    to = 0;
    prev_st = bus.seq_state;
    prev_f = bus.fault_count;
    while (cyc < 30000 && !(bus.fault_count == 8'd255 && to >= 2)) begin
      @(posedge clk); #1;
      bus.relock_req = (bus.seq_state == 3'd5);
      if (prev_st == 3'd1 && (bus.seq_state == 3'd0 || bus.seq_state == 3'd5) && prev_f == 8'd255)
        to++;
      prev_st = bus.seq_state;
      prev_f = bus.fault_count;
      cyc++;
    end
    bus.relock_req = 1'b0;
    check("sat_timeouts_seen", 32'(to >= 2), 32'd1);
    check("fault_saturated", 32'(bus.fault_count), 32'd255);
    check("sat_dom", 32'(bus.domain_rst_n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the main PLL from the 50 MHz board reference clock: pulses the PLL reset, waits for lock, qualifies lock stability, then releases the per-output-clock domain resets one at a time.
- Monitors lock in RUN; loss of lock or a software relock request restarts the sequence.
- Sits between the board reset pin and the PLL wrapper; also feeds the per-domain reset synchronisers.

Parameters:
- RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
- LOCK_TIMEOUT, 65536, cycles to wait for synchronised lock before retrying (~1.3 ms)
- STABLE_CYCLES, 1024, consecutive cycles lock must stay high before release
- NUM_DOMAINS, 5, number of downstream domain resets (one per PLL output clock)
- STAGGER_CYCLES, 64, cycles between successive domain releases
- MAX_RETRIES, 7, failed attempts before FAIL (only with macro)

Ports:
- refclk  in  1  50 MHz board clock, free-running, not from the PLL
- rst_n  in  1  synchronous active-low reset
- pll_locked  in  1  raw PLL locked, asynchronous
- relock_req  in  1  one-cycle pulse requesting a full re-lock
- pll_rst  out  1  active-high reset to PLL
- domain_rst_n  out  NUM_DOMAINS  active-low domain resets, bit 0 released first
- ready  out  1  high only in RUN
- fault_count  out  8  saturating count of timeouts plus lock losses
- seq_state  out  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, refclk. Reset is synchronous and active-low on rst_n.
- Reset values, applied while rst_n=0:
  - state = PLL_RST, pll_rst=1, domain_rst_n=all 0, ready=0, fault_count=0, all counters 0.
- Lock input: pll_locked passes through a 2-flop synchroniser to give lk. All lock decisions use lk, so there is 2 cycles of input latency.
- Single down-counter cnt; it is reloaded on every state entry.
- States and encoding:
  - PLL_RST (0): pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK (1): pll_rst=0. If lk=1, go to STABLE. If cnt reaches 0 with lk=0: fault_count+1, retry+1, go to PLL_RST.
  - STABLE (2): lk must stay 1 for STABLE_CYCLES consecutive cycles, then go to RELEASE. If lk drops: go to WAIT_LOCK with the timeout reloaded; no fault is counted.
  - RELEASE (3): release bit i, then wait STAGGER_CYCLES, then release bit i+1. Bit 0 is released on the first RELEASE cycle. After the last bit is released, go to RUN on the next cycle.
    - If lk drops: fault+1, go to PLL_RST.
    - Released bits are reasserted (0) on the same edge as the PLL_RST entry.
  - RUN (4): ready=1, retry counter cleared. lk=0 gives fault+1 and goes to PLL_RST. relock_req=1 goes to PLL_RST with no fault.
  - FAIL (5): exists only with the macro.
- On any entry to PLL_RST: domain_rst_n=0 and ready=0, both registered on that same edge.
- relock_req outside RUN: ignored.
- Simultaneous events in RUN, lk=0 together with relock_req: treated as a lock loss, fault counted once.
- fault_count: saturates at 255 and never wraps.
- rst_n low in any state: all outputs return to reset values on the next edge.
- Counter widths come from $clog2 of each parameter. A parameter value of 1 must work, with no zero-width counters.

Optional Feature:
- Macro PLLSEQ_RETRY_LIMIT_EN.
- Defined:
  - A 4-bit retry counter, incremented on each WAIT_LOCK timeout.
  - When it exceeds MAX_RETRIES: enter FAIL, with pll_rst=1, domain_rst_n=0, ready=0.
  - FAIL exits only on rst_n=0 or relock_req, both of which clear the retry counter.
- Undefined:
  - Retries forever.
  - FAIL is unreachable and the retry counter is not synthesised.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum (PLL_RST..FAIL, 3 bits)
  - the FAULT_W=8 constant
  - the seq_state encoding, shared with debug/UART status logic.
- One sub-module, sync2: a generic 2-flop synchroniser with reset value 0, used for pll_locked.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, NUM_DOMAINS=3, STAGGER_CYCLES=4, MAX_RETRIES=2):
1. rst_n deasserted, pll_locked rises 10 cycles later and stays high:
   - pll_rst high 4 cycles.
   - domain_rst_n goes 000 → 001 → 011 → 111 at 4-cycle spacing.
   - ready=1 one cycle after 111.
   - fault_count=0.
2. pll_locked never rises: a PLL_RST pulse every 4+32 cycles, fault_count increments by 1 per attempt, domain_rst_n stays 000.
3. In RUN, pll_locked drops for 1 cycle:
   - 3 cycles later domain_rst_n=000, ready=0, pll_rst=1, fault_count=1.
   - Full re-sequence on relock.
4. pll_locked glitches low in the middle of STABLE: returns to WAIT_LOCK, fault_count unchanged, release delayed by a full STABLE_CYCLES.
5. relock_req pulse in RUN, with lk=0 on the same cycle: single fault increment. relock_req in WAIT_LOCK: no effect.
6. Macro defined, no lock:
   - After the 3rd timeout, seq_state=5 and stays there.
   - relock_req restarts at PLL_RST.
   - Force fault_count to 255, then another timeout: it stays 255.
